// File: rtl/cpu_pkg.sv
// Shared core definitions: the canonical NOP and the IF->ID pipeline entry layout.
package cpu_pkg;

  localparam int unsigned CpuXlen = 32;

  // addi x0, x0, 0
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [CpuXlen-1:0] pc;
    logic [31:0]        instr;
    logic [CpuXlen-1:0] pc_plus4;
  } fetch_entry_t;

endpackage

// File: rtl/fdq_ptr_ctrl.sv
// Pointer, occupancy and handshake control for the fetch/decode queue.
// Qualifies push/pop against flush and fullness and produces the PC-register stall.
// Optional occupancy output is present only when FETCH_QUEUE_STATS_EN is defined.
module fdq_ptr_ctrl #(
  parameter int unsigned DEPTH = 2,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          valid_f,
  input  logic          stall_d,
  input  logic          flush_d,
  output logic          push,
  output logic          stall_f,
  output logic          valid_d,
  output logic [AW-1:0] rd_ptr,
  output logic [AW-1:0] wr_ptr
`ifdef FETCH_QUEUE_STATS_EN
  ,
  output logic [AW:0]   count
`endif
);

  localparam logic [AW:0] CountFull = (AW+1)'(DEPTH);

  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          pop;

  // Handshake qualification; a pop frees a slot in the same cycle so full+pop still accepts.
  always_comb begin
    valid_d = (count_q != '0);
    pop     = valid_d & ~stall_d & ~flush_d;
    stall_f = (count_q == CountFull) & ~pop;
    push    = valid_f & ~stall_f & ~flush_d;
  end

  // Next-state for pointers and occupancy; flush empties the queue and drops any push.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush_d) begin
      rd_ptr_d = wr_ptr_q;
      count_d  = '0;
    end else begin
      // Power-of-two depth: pointers wrap by natural overflow.
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      unique case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  assign rd_ptr = rd_ptr_q;
  assign wr_ptr = wr_ptr_q;
`ifdef FETCH_QUEUE_STATS_EN
  assign count  = count_q;
`endif

endmodule

// File: rtl/fetch_decode_queue.sv
// Buffered IF->ID boundary: small FIFO of {PC, instruction, PC+4} with the oldest entry
// presented combinationally to decode (NOP/0/0 when empty). Asserts StallF when full.
// Define FETCH_QUEUE_STATS_EN to add StallCntF (saturating stall-cycle count) and MaxOccD
// (occupancy high-water mark). XLEN must equal cpu_pkg::CpuXlen (entry layout is shared).
module fetch_decode_queue
  import cpu_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned XLEN  = 32
) (
  input  logic                     CLK,
  input  logic                     RESET_N,
  input  logic                     ValidF,
  input  logic [XLEN-1:0]          PCF,
  input  logic [31:0]              InstrF,
  input  logic [XLEN-1:0]          PCPlus4F,
  input  logic                     StallD,
  input  logic                     FlushD,
  output logic                     StallF,
  output logic                     ValidD,
  output logic [31:0]              InstrD,
  output logic [XLEN-1:0]          PCD,
  output logic [XLEN-1:0]          PCPlus4D
`ifdef FETCH_QUEUE_STATS_EN
  ,
  output logic [31:0]              StallCntF,
  output logic [$clog2(DEPTH):0]   MaxOccD
`endif
);

  localparam int unsigned AW = $clog2(DEPTH);

  fetch_entry_t  mem [DEPTH];
  fetch_entry_t  head;
  logic          push;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
`ifdef FETCH_QUEUE_STATS_EN
  logic [AW:0]   count;
`endif

  fdq_ptr_ctrl #(
    .DEPTH (DEPTH)
  ) u_ptr_ctrl (
    .clk     (CLK),
    .rst_n   (RESET_N),
    .valid_f (ValidF),
    .stall_d (StallD),
    .flush_d (FlushD),
    .push    (push),
    .stall_f (StallF),
    .valid_d (ValidD),
    .rd_ptr  (rd_ptr),
    .wr_ptr  (wr_ptr)
`ifdef FETCH_QUEUE_STATS_EN
    ,
    .count   (count)
`endif
  );

  // Entry storage; contents are don't-care out of reset since ValidD gates them.
  always_ff @(posedge CLK) begin
    if (push) begin
      mem[wr_ptr] <= '{pc: PCF, instr: InstrF, pc_plus4: PCPlus4F};
    end
  end

  // Head mux: oldest entry, or a NOP bubble when empty.
  always_comb begin
    head = mem[rd_ptr];
    if (ValidD) begin
      InstrD   = head.instr;
      PCD      = head.pc;
      PCPlus4D = head.pc_plus4;
    end else begin
      InstrD   = NOP_INSTR;
      PCD      = '0;
      PCPlus4D = '0;
    end
  end

`ifdef FETCH_QUEUE_STATS_EN
  logic [31:0] stall_cnt_q;
  logic [AW:0] max_occ_q;

  // Saturating stall counter and occupancy high-water register.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      stall_cnt_q <= '0;
      max_occ_q   <= '0;
    end else begin
      if (StallF && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + 1'b1;
      if (count > max_occ_q)             max_occ_q   <= count;
    end
  end

  // High-water reflects the current occupancy immediately, not one cycle late.
  always_comb begin
    StallCntF = stall_cnt_q;
    MaxOccD   = (count > max_occ_q) ? count : max_occ_q;
  end
`endif

endmodule

// File: tb/tb_fetch_decode_queue.sv
// Scoreboard bench for fetch_decode_queue (DEPTH=2). Stimulus drives each cycle at the falling
// edge, checks StallF/ValidD/head against a bench-side occupancy model, and pushes accepted
// entries into a queue; a separate monitor pops and compares whenever the DUT dequeues.
module tb_fetch_decode_queue;

  localparam int unsigned DEPTH = 2;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] pc4;
  } exp_t;

  logic        CLK = 1'b0;
  logic        RESET_N;
  logic        ValidF;
  logic [31:0] PCF;
  logic [31:0] InstrF;
  logic [31:0] PCPlus4F;
  logic        StallD;
  logic        FlushD;
  logic        StallF;
  logic        ValidD;
  logic [31:0] InstrD;
  logic [31:0] PCD;
  logic [31:0] PCPlus4D;
`ifdef FETCH_QUEUE_STATS_EN
  logic [31:0] StallCntF;
  logic [1:0]  MaxOccD;
`endif

  fetch_decode_queue #(
    .DEPTH (DEPTH),
    .XLEN  (32)
  ) dut (
    .CLK      (CLK),
    .RESET_N  (RESET_N),
    .ValidF   (ValidF),
    .PCF      (PCF),
    .InstrF   (InstrF),
    .PCPlus4F (PCPlus4F),
    .StallD   (StallD),
    .FlushD   (FlushD),
    .StallF   (StallF),
    .ValidD   (ValidD),
    .InstrD   (InstrD),
    .PCD      (PCD),
    .PCPlus4D (PCPlus4D)
`ifdef FETCH_QUEUE_STATS_EN
    ,
    .StallCntF (StallCntF),
    .MaxOccD   (MaxOccD)
`endif
  );

  always #5 CLK = ~CLK;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   model_count = 0;
  exp_t sb[$];

  function automatic logic [31:0] instr_of(input logic [31:0] pc);
    return 32'h0010_0093 ^ (pc << 7);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // One cycle: drive at the falling edge, check combinational outputs, advance the model.
  task automatic cycle(input logic vf, input logic [31:0] pc, input logic sd, input logic fd);
    logic exp_valid, exp_pop, exp_stall, exp_push;
    @(negedge CLK);
    ValidF   = vf;
    PCF      = pc;
    InstrF   = instr_of(pc);
    PCPlus4F = pc + 32'd4;
    StallD   = sd;
    FlushD   = fd;
    #1;
    exp_valid = (model_count > 0);
    exp_pop   = exp_valid && !sd && !fd;
    exp_stall = (model_count == DEPTH) && !exp_pop;
    exp_push  = vf && !exp_stall && !fd;
    chk("ValidD", {31'd0, ValidD}, {31'd0, exp_valid});
    chk("StallF", {31'd0, StallF}, {31'd0, exp_stall});
    if (exp_valid) begin
      chk("head_PCD", PCD, sb[0].pc);
      chk("head_InstrD", InstrD, sb[0].instr);
    end else begin
      chk("empty_InstrD", InstrD, NOP);
      chk("empty_PCD", PCD, 32'd0);
      chk("empty_PCPlus4D", PCPlus4D, 32'd0);
    end
    if (fd) begin
      sb.delete();
      model_count = 0;
    end else begin
      if (exp_push) begin
        sb.push_back('{pc: pc, instr: instr_of(pc), pc4: pc + 32'd4});
        model_count++;
      end
      if (exp_pop) model_count--;
    end
  endtask

  // Monitor: whenever the DUT dequeues, the head must match the oldest expected entry.
  initial begin
    exp_t e;
    forever begin
      @(negedge CLK);
      #2;
      if (RESET_N && ValidD && !StallD && !FlushD) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL deq_unexpected: got PCD %h expected no entry at %0t", PCD, $time);
        end else begin
          e = sb.pop_front();
          chk("deq_PCD", PCD, e.pc);
          chk("deq_InstrD", InstrD, e.instr);
          chk("deq_PCPlus4D", PCPlus4D, e.pc4);
        end
      end
    end
  end

  // Watchdog so the run always terminates.
  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    RESET_N = 1'b0;
    ValidF = 1'b1; PCF = 32'h40; InstrF = instr_of(32'h40); PCPlus4F = 32'h44;
    StallD = 1'b0; FlushD = 1'b0;

    // 1: reset holds the queue empty despite ValidF
    repeat (3) @(negedge CLK);
    #1;
    chk("rst_ValidD", {31'd0, ValidD}, 32'd0);
    chk("rst_InstrD", InstrD, NOP);
    chk("rst_PCD", PCD, 32'd0);
    chk("rst_StallF", {31'd0, StallF}, 32'd0);
`ifdef FETCH_QUEUE_STATS_EN
    chk("rst_StallCntF", StallCntF, 32'd0);
    chk("rst_MaxOccD", {30'd0, MaxOccD}, 32'd0);
`endif
    ValidF  = 1'b0;
    RESET_N = 1'b1;
    cycle(1'b0, 32'h0, 1'b0, 1'b0);
    cycle(1'b0, 32'h0, 1'b0, 1'b0);

    // 2: streaming, PCD follows PCF one cycle later
    for (int i = 0; i < 6; i++) cycle(1'b1, 32'(i * 4), 1'b0, 1'b0);
    cycle(1'b0, 32'h0, 1'b0, 1'b0);
    cycle(1'b0, 32'h0, 1'b0, 1'b0);

    // 3: back-pressure fills the queue; fetch holds 0x108 while stalled
    cycle(1'b1, 32'h100, 1'b1, 1'b0);
    cycle(1'b1, 32'h104, 1'b1, 1'b0);
    cycle(1'b1, 32'h108, 1'b1, 1'b0);
    cycle(1'b1, 32'h108, 1'b1, 1'b0);
    // 4: full + pop accepts 0x108
    cycle(1'b1, 32'h108, 1'b0, 1'b0);
    cycle(1'b1, 32'h10C, 1'b0, 1'b0);
    repeat (3) cycle(1'b0, 32'h0, 1'b0, 1'b0);

    // 5: flush with concurrent fetch discards everything, 0x300 follows
    cycle(1'b1, 32'h180, 1'b1, 1'b0);
    cycle(1'b1, 32'h184, 1'b1, 1'b0);
    cycle(1'b1, 32'h200, 1'b1, 1'b1);
    cycle(1'b1, 32'h300, 1'b0, 1'b0);
    cycle(1'b0, 32'h0, 1'b0, 1'b0);
    cycle(1'b0, 32'h0, 1'b0, 1'b0);

    // 6: async reset between edges
    cycle(1'b1, 32'h400, 1'b1, 1'b0);
    cycle(1'b1, 32'h404, 1'b1, 1'b0);
    cycle(1'b0, 32'h0, 1'b1, 1'b0);
    #1;
    RESET_N = 1'b0;
    #1;
    chk("async_ValidD", {31'd0, ValidD}, 32'd0);
    chk("async_InstrD", InstrD, NOP);
    chk("async_StallF", {31'd0, StallF}, 32'd0);
    sb.delete();
    model_count = 0;
`ifdef FETCH_QUEUE_STATS_EN
    chk("async_StallCntF", StallCntF, 32'd0);
    chk("async_MaxOccD", {30'd0, MaxOccD}, 32'd0);
`endif
    @(negedge CLK);
    RESET_N = 1'b1;
    cycle(1'b0, 32'h0, 1'b0, 1'b0);
    cycle(1'b1, 32'h500, 1'b0, 1'b0);
    cycle(1'b0, 32'h0, 1'b0, 1'b0);
    cycle(1'b0, 32'h0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
